// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS sequencer: instruction fields,
// ALU operation codes, datapath mux selects, FSM states and decoded classes.
package mc_ctrl_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_NOOP    = 6'b000000;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;
  localparam logic [5:0] FN_ADD     = 6'b100000;
  localparam logic [5:0] FN_SUB     = 6'b100010;
  localparam logic [5:0] FN_SLT     = 6'b101010;

  // ALU operation codes
  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_SUB  = 6'b100010;
  localparam logic [5:0] ALU_SLT  = 6'b101010;
  localparam logic [5:0] ALU_XOR  = 6'b100110;
  localparam logic [5:0] ALU_PASS = 6'b101100;

  // PC source mux
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_REGA   = 2'b11;

  // ALU B operand mux
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_EXEC_R, S_R_WB, S_EXEC_I, S_I_WB, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    CL_NOOP, CL_LW, CL_SW, CL_ADD, CL_SUB, CL_SLT, CL_XORI,
    CL_BNE, CL_J, CL_JAL, CL_JR, CL_SYSCALL, CL_ILLEGAL
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct to instruction class,
// with an illegal flag for anything the sequencer does not implement.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output iclass_t    o_class,
  output logic       o_illegal
);

  // Classify opcode, then funct for R-type
  always_comb begin
    o_class = CL_ILLEGAL;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_NOOP:    o_class = CL_NOOP;
          FN_ADD:     o_class = CL_ADD;
          FN_SUB:     o_class = CL_SUB;
          FN_SLT:     o_class = CL_SLT;
          FN_JR:      o_class = CL_JR;
          FN_SYSCALL: o_class = CL_SYSCALL;
          default:    o_class = CL_ILLEGAL;
        endcase
      end
      OP_J:    o_class = CL_J;
      OP_JAL:  o_class = CL_JAL;
      OP_BNE:  o_class = CL_BNE;
      OP_XORI: o_class = CL_XORI;
      OP_LW:   o_class = CL_LW;
      OP_SW:   o_class = CL_SW;
      default: o_class = CL_ILLEGAL;
    endcase
  end

  assign o_illegal = (o_class == CL_ILLEGAL);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle sequencer for the MIPS core. Steps the shared datapath through
// fetch/decode/execute/memory/writeback, owns the memory request handshake
// and latches a sticky halt on SYSCALL.
// Optional: define MCCTRL_PERF_EN to build cycle/instruction counters;
// otherwise cycle_count/instr_count are tied to zero.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter logic [1:0] RESET_PC_SOURCE = 2'b00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        mem_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic [1:0]  pc_source,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [5:0]  alu_op,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        wri_data_sel,
  output logic        halt,
  output logic        illegal,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
);

  state_t  r_state;
  state_t  w_next;
  logic    r_is_sw;
  iclass_t w_class;
  logic    w_dec_illegal;

  logic       w_mem_read, w_mem_write, w_iord, w_ir_write, w_pc_write;
  logic       w_pc_write_cond, w_alu_src_a, w_reg_write, w_reg_dst;
  logic       w_mem_to_reg, w_wri_data_sel, w_halt, w_illegal;
  logic [1:0] w_pc_source, w_alu_src_b;
  logic [5:0] w_alu_op;

  mc_decode u_decode (
    .i_opcode  (opcode),
    .i_funct   (funct),
    .o_class   (w_class),
    .o_illegal (w_dec_illegal)
  );

  // State register; LW/SW choice is captured in DECODE so MEM_ADDR need not
  // look at the opcode again
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
      r_is_sw <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_is_sw <= (w_class == CL_SW);
    end
  end

  // Next-state and per-state control decode
  always_comb begin
    w_next          = r_state;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_iord          = 1'b0;
    w_ir_write      = 1'b0;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_pc_source     = PCS_ALU;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = SRCB_B;
    w_alu_op        = ALU_PASS;
    w_reg_write     = 1'b0;
    w_reg_dst       = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_wri_data_sel  = 1'b0;
    w_halt          = 1'b0;
    w_illegal       = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = SRCB_FOUR;
        w_alu_op    = ALU_ADD;
        if (mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        w_alu_src_b = SRCB_IMM_SH;
        w_alu_op    = ALU_ADD;
        w_illegal   = w_dec_illegal;
        case (w_class)
          CL_LW, CL_SW:          w_next = S_MEM_ADDR;
          CL_ADD, CL_SUB, CL_SLT: w_next = S_EXEC_R;
          CL_XORI:               w_next = S_EXEC_I;
          CL_BNE:                w_next = S_BRANCH;
          CL_J, CL_JAL, CL_JR:   w_next = S_JUMP;
          CL_SYSCALL:            w_next = S_HALT;
          default:               w_next = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_alu_op    = ALU_ADD;
        w_next      = r_is_sw ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
        if (mem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        w_reg_write    = 1'b1;
        w_mem_to_reg   = 1'b1;
        w_wri_data_sel = 1'b1;
        w_next         = S_FETCH;
      end
      S_MEM_WR: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXEC_R: begin
        w_alu_src_a = 1'b1;
        case (w_class)
          CL_SUB:  w_alu_op = ALU_SUB;
          CL_SLT:  w_alu_op = ALU_SLT;
          default: w_alu_op = ALU_ADD;
        endcase
        w_next = S_R_WB;
      end
      S_R_WB: begin
        w_reg_write    = 1'b1;
        w_reg_dst      = 1'b1;
        w_wri_data_sel = 1'b1;
        w_next         = S_FETCH;
      end
      S_EXEC_I: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_alu_op    = ALU_XOR;
        w_next      = S_I_WB;
      end
      S_I_WB: begin
        w_reg_write    = 1'b1;
        w_wri_data_sel = 1'b1;
        w_next         = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_alu_op        = ALU_SUB;
        w_pc_write_cond = 1'b1;
        w_pc_source     = PCS_ALUOUT;
        w_next          = S_FETCH;
      end
      S_JUMP: begin
        w_pc_write = 1'b1;
        case (w_class)
          CL_JR:   w_pc_source = PCS_REGA;
          CL_JAL: begin
            w_pc_source = PCS_JUMP;
            w_reg_write = 1'b1;
          end
          default: w_pc_source = PCS_JUMP;
        endcase
        w_next = S_FETCH;
      end
      S_HALT: begin
        w_halt = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Reset forces outputs combinationally so an in-flight request drops at once
  assign mem_read      = reset_n & w_mem_read;
  assign mem_write     = reset_n & w_mem_write;
  assign iord          = reset_n & w_iord;
  assign ir_write      = reset_n & w_ir_write;
  assign pc_write      = reset_n & w_pc_write;
  assign pc_write_cond = reset_n & w_pc_write_cond;
  assign pc_source     = reset_n ? w_pc_source : RESET_PC_SOURCE;
  assign alu_src_a     = reset_n & w_alu_src_a;
  assign alu_src_b     = reset_n ? w_alu_src_b : 2'b00;
  assign alu_op        = reset_n ? w_alu_op : 6'b000000;
  assign reg_write     = reset_n & w_reg_write;
  assign reg_dst       = reset_n & w_reg_dst;
  assign mem_to_reg    = reset_n & w_mem_to_reg;
  assign wri_data_sel  = reset_n & w_wri_data_sel;
  assign halt          = reset_n & w_halt;
  assign illegal       = reset_n & w_illegal;

`ifdef MCCTRL_PERF_EN
  logic [31:0] r_cycle_count;
  logic [31:0] r_instr_count;
  logic        w_retire;

  assign w_retire = ((r_state != S_FETCH) && (w_next == S_FETCH)) ||
                    ((r_state != S_HALT)  && (w_next == S_HALT));

  // Performance counters, free-running modulo 2^32
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cycle_count <= '0;
      r_instr_count <= '0;
    end else begin
      if (r_state != S_HALT) r_cycle_count <= r_cycle_count + 32'd1;
      if (w_retire)          r_instr_count <= r_instr_count + 32'd1;
    end
  end

  assign cycle_count = r_cycle_count;
  assign instr_count = r_instr_count;
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver pushes the expected
// control vector for every cycle it drives; a negedge monitor pops and
// compares against the DUT outputs.
module tb_multicycle_control;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [5:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       wri_data_sel;
    logic       halt;
    logic       illegal;
  } ctrl_t;

  typedef enum {
    P_FETCH_W, P_FETCH_R, P_DECODE, P_DECODE_ILL, P_MEM_ADDR, P_MEM_RD,
    P_MEM_WB, P_MEM_WR, P_EXEC_ADD, P_EXEC_SUB, P_EXEC_SLT, P_R_WB,
    P_EXEC_I, P_I_WB, P_BRANCH, P_J, P_JAL, P_JR, P_HALT, P_RESET
  } phase_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        mem_ready = 1'b0;
  logic        mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
  logic [1:0]  pc_source, alu_src_b;
  logic        alu_src_a, reg_write, reg_dst, mem_to_reg, wri_data_sel;
  logic        halt, illegal;
  logic [5:0]  alu_op;
  logic [31:0] cycle_count, instr_count;
  ctrl_t       dut_v;

  int tests = 0;
  int fails = 0;
  int bench_cyc = 0;
  int bench_instr = 0;
  string cur_name = "reset";

  ctrl_t exp_q[$];
  string name_q[$];

  multicycle_control #(.RESET_PC_SOURCE(2'b00)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .wri_data_sel(wri_data_sel), .halt(halt), .illegal(illegal),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign dut_v = {mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
                  pc_source, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst,
                  mem_to_reg, wri_data_sel, halt, illegal};

  // Hand-written control table for each expected cycle
  function automatic ctrl_t exp_of(phase_t p);
    ctrl_t c;
    c = '0;
    c.alu_op = 6'b101100;
    case (p)
      P_FETCH_W: begin c.mem_read = 1; c.alu_src_b = 2'b01; c.alu_op = 6'b100000; end
      P_FETCH_R: begin
        c.mem_read = 1; c.alu_src_b = 2'b01; c.alu_op = 6'b100000;
        c.ir_write = 1; c.pc_write = 1;
      end
      P_DECODE:     begin c.alu_src_b = 2'b11; c.alu_op = 6'b100000; end
      P_DECODE_ILL: begin c.alu_src_b = 2'b11; c.alu_op = 6'b100000; c.illegal = 1; end
      P_MEM_ADDR:   begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 6'b100000; end
      P_MEM_RD:     begin c.mem_read = 1; c.iord = 1; end
      P_MEM_WB:     begin c.reg_write = 1; c.mem_to_reg = 1; c.wri_data_sel = 1; end
      P_MEM_WR:     begin c.mem_write = 1; c.iord = 1; end
      P_EXEC_ADD:   begin c.alu_src_a = 1; c.alu_op = 6'b100000; end
      P_EXEC_SUB:   begin c.alu_src_a = 1; c.alu_op = 6'b100010; end
      P_EXEC_SLT:   begin c.alu_src_a = 1; c.alu_op = 6'b101010; end
      P_R_WB:       begin c.reg_write = 1; c.reg_dst = 1; c.wri_data_sel = 1; end
      P_EXEC_I:     begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 6'b100110; end
      P_I_WB:       begin c.reg_write = 1; c.wri_data_sel = 1; end
      P_BRANCH: begin
        c.alu_src_a = 1; c.alu_op = 6'b100010; c.pc_write_cond = 1; c.pc_source = 2'b01;
      end
      P_J:      begin c.pc_write = 1; c.pc_source = 2'b10; end
      P_JAL:    begin c.pc_write = 1; c.pc_source = 2'b10; c.reg_write = 1; end
      P_JR:     begin c.pc_write = 1; c.pc_source = 2'b11; end
      P_HALT:   begin c.halt = 1; end
      P_RESET:  begin c = '0; end
      default:  begin c = '0; end
    endcase
    return c;
  endfunction

  task automatic check_vec(input string n, input ctrl_t got, input ctrl_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", n, got, exp);
    end
  endtask

  task automatic check32(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask

  // Monitor: one expectation per driven cycle, compared mid-cycle
  always @(negedge clk) begin
    ctrl_t e;
    string n;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check_vec(n, dut_v, e);
    end
  end

  task automatic set_instr(input string n, input logic [5:0] op, input logic [5:0] fn);
    cur_name = n;
    opcode = op;
    funct = fn;
  endtask

  // Drive one cycle starting just after a rising edge
  task automatic cyc(input phase_t p, input logic rdy);
    mem_ready = rdy;
    exp_q.push_back(exp_of(p));
    name_q.push_back($sformatf("%s_%s", cur_name, p.name()));
    if (p != P_HALT) bench_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic done();
    bench_instr++;
  endtask

  initial begin
    logic [31:0] exp_cc;
    logic [31:0] exp_ic;

    #12;
    check_vec("reset_outputs", dut_v, exp_of(P_RESET));
    check32("reset_cycle_count", cycle_count, 32'd0);
    check32("reset_instr_count", instr_count, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    set_instr("add", 6'b000000, 6'b100000);
    cyc(P_FETCH_R, 1); cyc(P_DECODE, 1); cyc(P_EXEC_ADD, 1); cyc(P_R_WB, 1); done();

    set_instr("lw_wait", 6'b100011, 6'b000000);
    cyc(P_FETCH_W, 0); cyc(P_FETCH_W, 0); cyc(P_FETCH_R, 1);
    cyc(P_DECODE, 1); cyc(P_MEM_ADDR, 1);
    cyc(P_MEM_RD, 0); cyc(P_MEM_RD, 0); cyc(P_MEM_RD, 0); cyc(P_MEM_RD, 1);
    cyc(P_MEM_WB, 1); done();

    set_instr("sw", 6'b101011, 6'b000000);
    cyc(P_FETCH_R, 1); cyc(P_DECODE, 1); cyc(P_MEM_ADDR, 1); cyc(P_MEM_WR, 1); done();

    set_instr("bne", 6'b000101, 6'b000000);
    cyc(P_FETCH_R, 1); cyc(P_DECODE, 1); cyc(P_BRANCH, 1); done();

    set_instr("jal", 6'b000011, 6'b000000);
    cyc(P_FETCH_R, 1); cyc(P_DECODE, 1); cyc(P_JAL, 1); done();

    set_instr("jr", 6'b000000, 6'b001000);
    cyc(P_FETCH_R, 1); cyc(P_DECODE, 1); cyc(P_JR, 1); done();

    set_instr("j", 6'b000010, 6'b000000);
    cyc(P_FETCH_R, 1); cyc(P_DECODE, 1); cyc(P_J, 1); done();

    set_instr("sub", 6'b000000, 6'b100010);
    cyc(P_FETCH_R, 1); cyc(P_DECODE, 1); cyc(P_EXEC_SUB, 1); cyc(P_R_WB, 1); done();

    set_instr("slt", 6'b000000, 6'b101010);
    cyc(P_FETCH_R, 1); cyc(P_DECODE, 1); cyc(P_EXEC_SLT, 1); cyc(P_R_WB, 1); done();

    set_instr("xori", 6'b001110, 6'b000000);
    cyc(P_FETCH_R, 1); cyc(P_DECODE, 1); cyc(P_EXEC_I, 1); cyc(P_I_WB, 1); done();

    set_instr("noop", 6'b000000, 6'b000000);
    cyc(P_FETCH_R, 1); cyc(P_DECODE, 1); done();

    set_instr("ill_op", 6'b111111, 6'b000000);
    cyc(P_FETCH_R, 1); cyc(P_DECODE_ILL, 1); done();

    set_instr("ill_fn", 6'b000000, 6'b111111);
    cyc(P_FETCH_R, 1); cyc(P_DECODE_ILL, 1); done();

    // Idle fetch cycle used to sample the performance counters
    set_instr("perf", 6'b000000, 6'b000000);
`ifdef MCCTRL_PERF_EN
    exp_cc = bench_cyc;
    exp_ic = bench_instr;
`else
    exp_cc = 32'd0;
    exp_ic = 32'd0;
`endif
    mem_ready = 1'b0;
    exp_q.push_back(exp_of(P_FETCH_W));
    name_q.push_back("perf_FETCH_W");
    @(negedge clk);
    #1;
    check32("perf_cycle_count", cycle_count, exp_cc);
    check32("perf_instr_count", instr_count, exp_ic);
    bench_cyc++;
    @(posedge clk);
    #1;

    // Reset in the middle of a stalled store
    set_instr("sw_rst", 6'b101011, 6'b000000);
    cyc(P_FETCH_R, 1); cyc(P_DECODE, 1); cyc(P_MEM_ADDR, 1);
    cyc(P_MEM_WR, 0); cyc(P_MEM_WR, 0);
    mem_ready = 1'b0;
    #1;
    tests++;
    if (mem_write !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_mem_write: got %b expected 1", mem_write);
    end
    #1;
    reset_n = 1'b0;
    #1;
    check_vec("async_reset_outputs", dut_v, exp_of(P_RESET));
    check32("async_reset_cycle_count", cycle_count, 32'd0);
    check32("async_reset_instr_count", instr_count, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    bench_cyc = 0;
    bench_instr = 0;

    set_instr("after_rst", 6'b000000, 6'b000000);
    cyc(P_FETCH_W, 0); cyc(P_FETCH_R, 1); cyc(P_DECODE, 1); done();

    set_instr("syscall", 6'b000000, 6'b001100);
    cyc(P_FETCH_R, 1); cyc(P_DECODE, 1);
    for (int i = 0; i < 20; i++) cyc(P_HALT, 1);

    reset_n = 1'b0;
    #1;
    check_vec("halt_reset_outputs", dut_v, exp_of(P_RESET));
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    set_instr("post_halt", 6'b000000, 6'b000000);
    cyc(P_FETCH_W, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
